// File: rtl/stream_demux_pkg.sv
// Shared helpers for the registered stream demultiplexer: channel-count limits and the
// ceil(log2) used to check that the select is wide enough.
package stream_demux_pkg;

  localparam int unsigned MinCh = 2;
  localparam int unsigned MaxCh = 16;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slice for a single demux channel. A load always wins over a
// drain in the same cycle, so a slot can be emptied and refilled back to back.
module demux_slot #(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [BUS_WIDTH-1:0] d,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] q,
  output logic                 valid,
  output logic                 can_accept
);

  logic                 valid_d, valid_q;
  logic [BUS_WIDTH-1:0] data_d, data_q;

  assign can_accept = ~valid_q | out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end else if (valid_q && out_ready) begin
      // Data is left in place on drain; it is don't-care while invalid.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/stream_demux_nch.sv
// Registered valid/ready 1-to-N demux with broadcast. Beats whose select names no channel
// are sunk and counted in a saturating drop counter.
module stream_demux_nch
  import stream_demux_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BUS_WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_bcast,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [NUM_CH*BUS_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]           out_valid,
  input  logic [NUM_CH-1:0]           out_ready,
  output logic [CNT_W-1:0]            drop_cnt
);

  if (NUM_CH < MinCh || NUM_CH > MaxCh) begin : g_bad_num_ch
    $error("stream_demux_nch: NUM_CH must be within 2..16");
  end
  if (SEL_W < clog2(NUM_CH)) begin : g_bad_sel_w
    $error("stream_demux_nch: SEL_W too narrow to address NUM_CH channels");
  end

  logic [NUM_CH-1:0] sel_hit;
  logic [NUM_CH-1:0] can_accept;
  logic [NUM_CH-1:0] load;
  logic              sel_ok;
  logic              accept;
  logic [CNT_W-1:0]  drop_cnt_d, drop_cnt_q;

  always_comb begin
    sel_hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sel_hit[i] = (32'(in_sel) == i);
    end
  end

  assign sel_ok = |sel_hit;

  // Independent of in_valid so the producer may wait on ready before asserting valid.
  always_comb begin
    if (in_bcast) begin
      in_ready = &can_accept;
    end else if (sel_ok) begin
      in_ready = |(can_accept & sel_hit);
    end else begin
      in_ready = 1'b1;
    end
  end

  assign accept = in_valid & in_ready & ~reset;

  always_comb begin
    load = '0;
    if (accept) begin
      load = in_bcast ? '1 : sel_hit;
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && !in_bcast && !sel_ok && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .BUS_WIDTH(BUS_WIDTH)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[k]),
      .d         (in_data),
      .out_ready (out_ready[k]),
      .q         (out_data[k*BUS_WIDTH +: BUS_WIDTH]),
      .valid     (out_valid[k]),
      .can_accept(can_accept[k])
    );
  end

endmodule

// File: tb/tb_stream_demux_nch.sv
// Bench for stream_demux_nch: directed vector table, streaming and drop-counter sequences,
// then randomized traffic against an array-based reference model.
module tb_stream_demux_nch;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned N3 = 3;
  localparam int unsigned SW = 2;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Four-channel instance
  logic             reset;
  logic [W-1:0]     in_data;
  logic [SW-1:0]    in_sel;
  logic             in_bcast;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   out_data;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready;
  logic [CW-1:0]    drop_cnt;

  // Three-channel instance, so select value 3 is out of range
  logic             d3_reset;
  logic [W-1:0]     d3_in_data;
  logic [SW-1:0]    d3_in_sel;
  logic             d3_in_bcast;
  logic             d3_in_valid;
  logic             d3_in_ready;
  logic [N3*W-1:0]  d3_out_data;
  logic [N3-1:0]    d3_out_valid;
  logic [N3-1:0]    d3_out_ready;
  logic [CW-1:0]    d3_drop_cnt;

  stream_demux_nch #(
    .BUS_WIDTH(W),
    .NUM_CH   (N),
    .SEL_W    (SW),
    .CNT_W    (CW)
  ) u_dut4 (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_bcast (in_bcast),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .drop_cnt (drop_cnt)
  );

  stream_demux_nch #(
    .BUS_WIDTH(W),
    .NUM_CH   (N3),
    .SEL_W    (SW),
    .CNT_W    (CW)
  ) u_dut3 (
    .clk      (clk),
    .reset    (d3_reset),
    .in_data  (d3_in_data),
    .in_sel   (d3_in_sel),
    .in_bcast (d3_in_bcast),
    .in_valid (d3_in_valid),
    .in_ready (d3_in_ready),
    .out_data (d3_out_data),
    .out_valid(d3_out_valid),
    .out_ready(d3_out_ready),
    .drop_cnt (d3_drop_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  typedef struct {
    logic        rst;
    logic        vld;
    logic [1:0]  sel;
    logic        bc;
    logic [7:0]  d;
    logic [3:0]  rdy;
    logic        cr;     // compare in_ready on this row
    logic        e_rdy;
    logic [3:0]  e_ov;
    logic [31:0] e_d;    // {ch3, ch2, ch1, ch0}, compared only where e_ov is set
  } vec_t;

  localparam int NV = 15;
  vec_t vec [NV];

  // Reference model: per-channel slot contents kept as plain arrays
  bit           m_valid [N];
  logic [W-1:0] m_data  [N];

  function automatic bit model_ready(input bit bc, input int sel, input logic [N-1:0] rdy);
    bit all_ok = 1'b1;
    for (int k = 0; k < N; k++) if (m_valid[k] && !rdy[k]) all_ok = 1'b0;
    if (bc) return all_ok;
    if (sel >= N) return 1'b1;
    return !m_valid[sel] || rdy[sel];
  endfunction

  task automatic rand_cycle(input bit do_check);
    bit exp_rdy;
    bit acc;
    bit rst;
    logic [N-1:0] exp_ov;
    rst       = do_check ? ($urandom_range(0, 49) == 0) : 1'b1;
    reset     = rst;
    in_valid  = ($urandom_range(0, 3) != 0);
    in_sel    = SW'($urandom_range(0, 3));
    in_bcast  = ($urandom_range(0, 3) == 0);
    in_data   = W'($urandom);
    out_ready = N'($urandom);
    #1;
    exp_rdy = model_ready(in_bcast, int'(in_sel), out_ready);
    if (do_check) check("rand in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = in_valid && exp_rdy && !rst;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        m_valid[k] = 1'b0;
        m_data[k]  = '0;
      end else if (acc && (in_bcast || (int'(in_sel) == k))) begin
        m_valid[k] = 1'b1;
        m_data[k]  = in_data;
      end else if (m_valid[k] && out_ready[k]) begin
        m_valid[k] = 1'b0;
      end
      exp_ov[k] = m_valid[k];
    end
    if (do_check) begin
      check("rand out_valid", 32'(out_valid), 32'(exp_ov));
      for (int k = 0; k < N; k++) begin
        if (m_valid[k]) check($sformatf("rand data ch%0d", k), 32'(out_data[k*W +: W]),
                              32'(m_data[k]));
      end
      check("rand drop_cnt", 32'(drop_cnt), 32'd0);
    end
  endtask

  initial begin
    vec[0]  = '{1'b1, 1'b1, 2'd2, 1'b0, 8'hFF, 4'b1111, 1'b0, 1'b0, 4'b0000, 32'h0000_0000};
    vec[1]  = '{1'b1, 1'b1, 2'd2, 1'b0, 8'hFF, 4'b1111, 1'b1, 1'b1, 4'b0000, 32'h0000_0000};
    vec[2]  = '{1'b0, 1'b1, 2'd2, 1'b0, 8'hA5, 4'b1111, 1'b1, 1'b1, 4'b0100, 32'h00A5_0000};
    vec[3]  = '{1'b0, 1'b1, 2'd1, 1'b0, 8'h55, 4'b1101, 1'b1, 1'b1, 4'b0010, 32'h0000_5500};
    vec[4]  = '{1'b0, 1'b1, 2'd1, 1'b0, 8'h66, 4'b1101, 1'b1, 1'b0, 4'b0010, 32'h0000_5500};
    vec[5]  = '{1'b0, 1'b1, 2'd3, 1'b0, 8'h3C, 4'b1101, 1'b1, 1'b1, 4'b1010, 32'h3C00_5500};
    vec[6]  = '{1'b0, 1'b1, 2'd1, 1'b0, 8'h66, 4'b1111, 1'b1, 1'b1, 4'b0010, 32'h0000_6600};
    vec[7]  = '{1'b0, 1'b1, 2'd0, 1'b1, 8'h7E, 4'b1111, 1'b1, 1'b1, 4'b1111, 32'h7E7E_7E7E};
    vec[8]  = '{1'b0, 1'b1, 2'd0, 1'b1, 8'h81, 4'b1110, 1'b1, 1'b0, 4'b0001, 32'h0000_007E};
    vec[9]  = '{1'b0, 1'b1, 2'd0, 1'b0, 8'h11, 4'b1111, 1'b1, 1'b1, 4'b0001, 32'h0000_0011};
    vec[10] = '{1'b0, 1'b1, 2'd0, 1'b0, 8'h22, 4'b1111, 1'b1, 1'b1, 4'b0001, 32'h0000_0022};
    vec[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 1'b1, 4'b0000, 32'h0000_0000};
    vec[12] = '{1'b0, 1'b1, 2'd0, 1'b1, 8'h99, 4'b0000, 1'b1, 1'b1, 4'b1111, 32'h9999_9999};
    vec[13] = '{1'b1, 1'b1, 2'd0, 1'b0, 8'h44, 4'b0000, 1'b1, 1'b0, 4'b0000, 32'h0000_0000};
    vec[14] = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 1'b1, 4'b0000, 32'h0000_0000};

    d3_reset     = 1'b1;
    d3_in_data   = '0;
    d3_in_sel    = '0;
    d3_in_bcast  = 1'b0;
    d3_in_valid  = 1'b0;
    d3_out_ready = '1;

    // Directed table
    for (int i = 0; i < NV; i++) begin
      reset     = vec[i].rst;
      in_valid  = vec[i].vld;
      in_sel    = vec[i].sel;
      in_bcast  = vec[i].bc;
      in_data   = vec[i].d;
      out_ready = vec[i].rdy;
      #1;
      if (vec[i].cr) check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vec[i].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vec[i].e_ov));
      for (int k = 0; k < N; k++) begin
        if (vec[i].e_ov[k]) check($sformatf("vec%0d data ch%0d", i, k),
                                  32'(out_data[k*W +: W]), 32'(vec[i].e_d[k*8 +: 8]));
      end
      check($sformatf("vec%0d drop_cnt", i), 32'(drop_cnt), 32'd0);
    end

    // Streaming: one beat per cycle round-robin, no gaps
    for (int i = 0; i < 16; i++) begin
      reset     = 1'b0;
      in_valid  = 1'b1;
      in_sel    = SW'(i % 4);
      in_bcast  = 1'b0;
      in_data   = W'(i);
      out_ready = '1;
      #1;
      check($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("stream%0d out_valid", i), 32'(out_valid), 32'(1 << (i % 4)));
      check($sformatf("stream%0d data", i), 32'(out_data[(i % 4)*W +: W]), 32'(i));
    end
    in_valid = 1'b0;

    // Out-of-range select on the three-channel instance; reset with valid held high
    d3_in_valid = 1'b1;
    d3_in_sel   = 2'd3;
    repeat (2) @(posedge clk);
    #1;
    check("d3 reset out_valid", 32'(d3_out_valid), 32'd0);
    check("d3 reset drop_cnt", 32'(d3_drop_cnt), 32'd0);
    d3_reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      d3_in_data = W'(i);
      #1;
      check("d3 in_ready", 32'(d3_in_ready), 32'd1);
      @(posedge clk);
      #1;
      check("d3 out_valid", 32'(d3_out_valid), 32'd0);
      check($sformatf("d3 drop_cnt beat%0d", i), 32'(d3_drop_cnt), 32'((i + 1 > 255) ? 255 : i + 1));
    end
    d3_reset = 1'b1;
    @(posedge clk);
    #1;
    check("d3 drop_cnt after reset", 32'(d3_drop_cnt), 32'd0);
    d3_in_valid = 1'b0;

    // Randomized traffic against the model, starting from a reset cycle
    rand_cycle(1'b0);
    for (int i = 0; i < 400; i++) rand_cycle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
